// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDUOp encoding, default
// latencies, the busy-counter width and the FSM state type.
package mdu_pkg;

  // MDUOp encoding; 7..15 behave as OpNone.
  localparam logic [3:0] OpNone  = 4'd0;
  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;
  localparam int unsigned CntW          = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

  // True for the ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_md_op(input logic [3:0] op);
    return (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit in the E stage. Owns HI/LO, runs mult/multu/div/divu
// with a fixed busy period and handles mthi/mtlo writes.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   A, B   - rs/rt operands (only sampled on the Start edge)
//   MDUOp  - operation select (see mdu_pkg)
//   Start  - one-cycle launch pulse for MULT/MULTU/DIV/DIVU
//   Wen    - write strobe for MTHI/MTLO
//   Busy   - registered, high while an operation is in flight
//   HI, LO - architectural HI/LO registers
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        Wen,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic            nowrite_q, nowrite_d;

  // ---------------------------------------------------------------------------
  // Combinational result of the requested operation
  // ---------------------------------------------------------------------------
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
  logic [31:0] umag_q, umag_r, sdiv_q, sdiv_r, udiv_q, udiv_r;
  logic [31:0] res_hi, res_lo;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out as
  // 0x80000000 rem 0 because the magnitude of INT_MIN is representable unsigned.
  assign a_mag    = A[31] ? (32'd0 - A) : A;
  assign b_mag    = B[31] ? (32'd0 - B) : B;
  // Divisor forced nonzero so the operators stay defined; the result is
  // discarded through nowrite anyway.
  assign b_mag_nz = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign b_nz     = (B == 32'd0) ? 32'd1 : B;
  assign umag_q   = a_mag / b_mag_nz;
  assign umag_r   = a_mag % b_mag_nz;
  assign sdiv_q   = (A[31] ^ B[31]) ? (32'd0 - umag_q) : umag_q;
  assign sdiv_r   = A[31] ? (32'd0 - umag_r) : umag_r;
  assign udiv_q   = A / b_nz;
  assign udiv_r   = A % b_nz;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (MDUOp)
      OpMult:  {res_hi, res_lo} = prod_s;
      OpMultu: {res_hi, res_lo} = prod_u;
      OpDiv: begin
        res_hi = sdiv_r;
        res_lo = sdiv_q;
      end
      OpDivu: begin
        res_hi = udiv_r;
        res_lo = udiv_q;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM / next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_tmp_d  = hi_tmp_q;
    lo_tmp_d  = lo_tmp_q;
    nowrite_d = nowrite_q;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          // Start always wins over Wen, even when the op is not launchable.
          if (is_md_op(MDUOp)) begin
            state_d   = StRun;
            cnt_d     = is_div_op(MDUOp) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            hi_tmp_d  = res_hi;
            lo_tmp_d  = res_lo;
            nowrite_d = is_div_op(MDUOp) && (B == 32'd0);
          end
        end else if (Wen) begin
          if (MDUOp == OpMthi) hi_d = A;
          if (MDUOp == OpMtlo) lo_d = A;
        end
      end
      StRun: begin
        // Start and Wen are ignored while running.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (!nowrite_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      hi_tmp_q  <= 32'd0;
      lo_tmp_q  <= 32'd0;
      nowrite_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_tmp_q  <= hi_tmp_d;
      lo_tmp_q  <= lo_tmp_d;
      nowrite_q <= nowrite_d;
    end
  end

  assign Busy = (state_q == StRun);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [3:0]  MDUOp = OpNone;
  logic        Start = 1'b0;
  logic        Wen = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;

  mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .MDUOp(MDUOp),
    .Start(Start),
    .Wen  (Wen),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] op, input logic [31:0] val);
    MDUOp = op;
    A     = val;
    Wen   = 1'b1;
    cyc();
    Wen   = 1'b0;
    MDUOp = OpNone;
    A     = 32'h0;
  endtask

  // Launch an op, check HI/LO hold during the busy period, the busy length and
  // the final HI/LO. Operands are scrambled after the start edge.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n, input logic [31:0] prev_hi,
                        input logic [31:0] prev_lo, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    MDUOp = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    MDUOp = OpNone;
    A     = 32'hDEADBEEF;
    B     = 32'h0BADF00D;
    checks++;
    if (HI !== prev_hi || LO !== prev_lo) begin
      errors++;
      $display("FAIL %s_early: HI=%h LO=%h, required HI=%h LO=%h", name, HI, LO, prev_hi,
               prev_lo);
    end
    n = 0;
    while (Busy === 1'b1 && n < 50) begin
      n++;
      cyc();
    end
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL %s_busy_len: got %0d cycles, required %0d", name, n, exp_n);
    end
    checks++;
    if (HI !== exp_hi) begin
      errors++;
      $display("FAIL %s_hi: got %h, required %h", name, HI, exp_hi);
    end
    checks++;
    if (LO !== exp_lo) begin
      errors++;
      $display("FAIL %s_lo: got %h, required %h", name, LO, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    checks++;
    if (HI !== 32'h0) begin
      errors++;
      $display("FAIL reset_hi: got %h, required %h", HI, 32'h0);
    end
    checks++;
    if (LO !== 32'h0) begin
      errors++;
      $display("FAIL reset_lo: got %h, required %h", LO, 32'h0);
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, required 0", Busy);
    end
    write_reg(OpMtlo, 32'h12345678);
    checks++;
    if (LO !== 32'h12345678) begin
      errors++;
      $display("FAIL mtlo_lo: got %h, required %h", LO, 32'h12345678);
    end
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0) begin
      errors++;
      $display("FAIL mtlo_side: Busy=%b HI=%h, required Busy=0 HI=0", Busy, HI);
    end
  endtask

  task automatic test_mult();
    run_op("mult", OpMult, 32'hFFFFFFFE, 32'd3, 5, 32'h0, 32'h12345678,
           32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", OpMultu, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA,
           32'h00000002, 32'hFFFFFFFA);
  endtask

  task automatic test_div();
    run_op("div", OpDiv, 32'hFFFFFFF9, 32'd2, 10, 32'h00000002, 32'hFFFFFFFA,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", OpDivu, 32'd7, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD,
           32'd1, 32'd3);
    run_op("div_ovf", OpDiv, 32'h80000000, 32'hFFFFFFFF, 10, 32'd1, 32'd3,
           32'h0, 32'h80000000);
    // 7 / -2 = -3 rem 1 (remainder follows the dividend)
    run_op("div_negb", OpDiv, 32'd7, 32'hFFFFFFFE, 10, 32'h0, 32'h80000000,
           32'd1, 32'hFFFFFFFD);
  endtask

  task automatic test_div_zero();
    write_reg(OpMthi, 32'hAA);
    write_reg(OpMtlo, 32'hBB);
    checks++;
    if (HI !== 32'hAA || LO !== 32'hBB) begin
      errors++;
      $display("FAIL preload: HI=%h LO=%h, required HI=000000aa LO=000000bb", HI, LO);
    end
    run_op("div0", OpDiv, 32'd123, 32'd0, 10, 32'hAA, 32'hBB, 32'hAA, 32'hBB);
    run_op("divu0", OpDivu, 32'hFFFFFFFF, 32'd0, 10, 32'hAA, 32'hBB, 32'hAA, 32'hBB);
  endtask

  task automatic test_ignored();
    int n;
    // MULTU 0x10000 * 0x10000 = 0x1_00000000
    MDUOp = OpMultu;
    A     = 32'h00010000;
    B     = 32'h00010000;
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 50) begin
      n++;
      Start = 1'b0;
      Wen   = 1'b0;
      if (n == 1) begin
        MDUOp = OpDiv;
        A     = 32'd100;
        B     = 32'd5;
        Start = 1'b1;
      end else if (n == 2) begin
        MDUOp = OpMthi;
        A     = 32'hDEAD0000;
        Wen   = 1'b1;
      end
      cyc();
    end
    Start = 1'b0;
    Wen   = 1'b0;
    MDUOp = OpNone;
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL ignored_busy_len: got %0d cycles, required 5", n);
    end
    checks++;
    if (HI !== 32'd1 || LO !== 32'd0) begin
      errors++;
      $display("FAIL ignored_result: HI=%h LO=%h, required HI=00000001 LO=00000000", HI, LO);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mult", OpMult, 32'd3, 32'd4, 5, 32'd1, 32'd0, 32'd0, 32'd12);
    // Launched in the very first idle cycle after the previous op.
    run_op("b2b_divu", OpDivu, 32'd100, 32'd7, 10, 32'd0, 32'd12, 32'd2, 32'd14);
    write_reg(OpMthi, 32'hCAFEF00D);
    checks++;
    if (HI !== 32'hCAFEF00D || LO !== 32'd14) begin
      errors++;
      $display("FAIL b2b_mthi: HI=%h LO=%h, required HI=cafef00d LO=0000000e", HI, LO);
    end
  endtask

  task automatic test_reset_mid();
    MDUOp = OpDiv;
    A     = 32'd100;
    B     = 32'd3;
    Start = 1'b1;
    cyc();
    Start = 1'b0;
    MDUOp = OpNone;
    cyc();
    cyc();
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy_before: got %b, required 1", Busy);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_after: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
    end
    for (int i = 0; i < 15; i++) cyc();
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_later: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the five-stage MIPS pipeline, sitting in E beside the ALU. It owns the HI/LO register pair and executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`. Operations are multi-cycle, and a registered `Busy` flag lets the hazard unit stall D-stage MD instructions. It is the sequential, arithmetic counterpart of the single-cycle D-stage operand comparator.

## Interface
**Parameters**
- `MULT_CYCLES`, default 5: busy duration in cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy duration in cycles for `div`/`divu`.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `A`, in, 32: rs operand, forwarded value from E.
- `B`, in, 32: rt operand, forwarded value from E.
- `MDUOp`, in, 4: operation select; encoding is in the package.
- `Start`, in, 1: one-cycle pulse that launches `MULT`/`MULTU`/`DIV`/`DIVU`.
- `Wen`, in, 1: write strobe for `MTHI`/`MTLO`.
- `Busy`, out, 1: registered; high while an operation is in flight.
- `HI`, out, 32: architectural HI register. The `mfhi` path reads it directly.
- `LO`, out, 32: architectural LO register. The `mflo` path reads it directly.

## Operation
- **Encoding** (`MDUOp`): NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6. Values 7–15 act as NONE.
- **States:** IDLE (`Busy`=0) and RUN (`Busy`=1, counter `cnt` nonzero).
- **IDLE → RUN:** occurs when `Start`=1 and `MDUOp` is MULT..DIVU.
  - The result is computed combinationally from `A`/`B` and latched into `hi_tmp`/`lo_tmp`.
  - `cnt` is loaded with `MULT_CYCLES` or `DIV_CYCLES`.
  - `A`/`B` need not be held after the start edge.
- **RUN:** `cnt` decrements by 1 every cycle.
- **RUN → IDLE:** on the edge where `cnt`==1, `HI`←`hi_tmp`, `LO`←`lo_tmp` and `Busy`←0.
- **MULT:** {HI,LO} = $signed(A) × $signed(B), full 64-bit product.
- **MULTU:** {HI,LO} = unsigned 64-bit product of A and B.
- **DIV:** LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **DIVU:** LO = unsigned quotient; HI = unsigned remainder.
- **Divide by zero** (`B`==0, DIV or DIVU):
  - The full busy period still runs.
  - HI and LO are left unchanged at completion; a `nowrite` flag is latched at start.
- **MTHI/MTLO:** when `Wen`=1 and `Busy`=0, HI (or LO) ← `A` at the next edge. `Busy` stays 0.
- **Ignored inputs:**
  - `Start` while `Busy`=1, and `Wen` while `Busy`=1. The hazard unit prevents both; the block must still not corrupt state.
  - `Start` together with `Wen` in the same cycle: `Start` wins and `Wen` is dropped.
  - `Start` with MTHI/MTLO/NONE: ignored.

## Timing
- **Reset values:** `HI`=0, `LO`=0, `Busy`=0, `cnt`=0, `hi_tmp`=0, `lo_tmp`=0, `nowrite`=0.
- **Reset mid-operation:** the operation is aborted, all state returns to reset values, and no HI/LO update occurs.
- **Start at edge T:**
  - `Busy` is 1 during cycles T+1 … T+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - New HI/LO become visible in cycle T+N+1, the same cycle `Busy` falls.
- **Back-to-back:** a new `Start` is accepted in the first cycle `Busy`=0.
- **MTHI/MTLO:** one-cycle latency; the value is visible the cycle after the `Wen` edge.
- **Hazard-unit contract:** stall a D-stage MD instruction when `Start`|`Busy` is high in E. This covers `mfhi`/`mflo`, so a read never sees a stale value.

## Structure
- Package `mdu_pkg` holds:
  - the `MDUOp` encoding constants;
  - default latencies 5 and 10;
  - the `cnt` width (4 bits).
- Single module. No sub-module is needed: the 64-bit product and the quotient/remainder are behavioural operators feeding the shadow registers.

## Test plan
- **Reset:** after reset, `HI`=0, `LO`=0, `Busy`=0. MTLO with A=0x12345678 → next cycle LO=0x12345678 and Busy stays 0.
- **MULT:** A=0xFFFFFFFE (−2), B=3 with Start → Busy high for exactly 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- **DIV:** A=0xFFFFFFF9 (−7), B=2 → Busy for 10 cycles. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with A=7, B=2 → LO=3, HI=1.
- **Divide by zero:** preload HI=0xAA, LO=0xBB, then DIV with B=0 → Busy for 10 cycles, then HI=0xAA, LO=0xBB unchanged.
- **Ignored inputs:** during a MULT in flight, pulse Start (DIV) and Wen (MTHI) → both ignored. Busy falls after the original 5 cycles and HI/LO hold the MULT result.
- **Reset mid-operation:** assert reset in the 3rd busy cycle of a DIV → next cycle Busy=0, HI=0, LO=0, and no later update occurs.
